// File: rtl/picomips_pkg.sv
// picomips_pkg
// Shared definitions for the picoMIPS core: opcode and state enums plus
// helpers giving the bit position of each instruction field.
// Instruction layout, MSB first: opcode[3] rd[RA] rs[RA] imm[N].
// No ports (package).
package picomips_pkg;

    localparam int OP_W    = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADDI = 3'b010,
        OP_IN   = 3'b011,
        OP_OUT  = 3'b100,
        OP_BEQZ = 3'b101,
        OP_MULI = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_IN,
        ST_WAIT_OUT,
        ST_HALT
    } state_t;

    function automatic int instr_size(input int n, input int ra);
        return OP_W + 2 * ra + n;
    endfunction

    function automatic int op_lsb(input int n, input int ra);
        return n + 2 * ra;
    endfunction

    function automatic int rd_lsb(input int n, input int ra);
        return n + ra;
    endfunction

    function automatic int rs_lsb(input int n);
        return n;
    endfunction

endpackage

// File: rtl/picomips_if.sv
// picomips_if
// Groups the switch-input and output-port handshakes of the core.
//   in_data/in_valid  : producer -> core, operand for IN
//   in_ready          : core -> producer, high while an IN is pending
//   outport/out_valid : core -> consumer, registered output value
//   out_ready         : consumer -> core
// Modport master is the core side, slave is the environment side.
interface picomips_if #(parameter int N = 8);

    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] outport;
    logic         out_valid;
    logic         out_ready;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, outport, out_valid
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, outport, out_valid
    );

endinterface

// File: rtl/picomips_alu.sv
// picomips_alu
// Combinational datapath of the core, all results modulo 2**N.
//   op     : decoded opcode
//   a      : rd operand
//   b      : rs operand (or in_data for IN), passed through for IN/OUT
//   imm    : immediate field
//   result : ADD a+b, ADDI a+imm, MULI fractional product, otherwise b
// Define PICOMIPS_MUL_EN to build the Q1.(N-1) multiplier for MULI;
// without it no multiplier exists and MULI yields the pass value.
import picomips_pkg::*;

module picomips_alu #(
    parameter int N = 8
) (
    input  opcode_t      op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] imm,
    output logic [N-1:0] result
);

`ifdef PICOMIPS_MUL_EN
    // Full 2N-bit signed product; the fractional result is bits [2N-2:N-1].
    logic signed [2*N-1:0] prod;

    always_comb begin
        prod = $signed({{N{b[N-1]}}, b}) * $signed({{N{imm[N-1]}}, imm});
    end
`endif

    // Opcode select; anything without arithmetic simply passes b.
    always_comb begin
        result = b;
        case (op)
            OP_ADD:  result = a + b;
            OP_ADDI: result = a + imm;
`ifdef PICOMIPS_MUL_EN
            OP_MULI: result = N'(prod >>> (N - 1));
`endif
            default: result = b;
        endcase
    end

endmodule

// File: rtl/picomips_core.sv
// picomips_core
// Single-cycle picoMIPS processor with handshaked input and output ports.
//   clk    : clock, rising edge
//   nreset : asynchronous active-low reset
//   pc     : address to external combinational program ROM
//   instr  : instruction at pc, same cycle
//   io     : picomips_if.master, switch input and output port handshakes
//   halted : high while in HALT
// Optional macro PICOMIPS_MUL_EN enables MULI; otherwise MULI is a NOP.
import picomips_pkg::*;

module picomips_core #(
    parameter int N     = 8,
    parameter int RA    = 2,
    parameter int PSIZE = 5,
    localparam int ISIZE = 3 + 2 * RA + N
) (
    input  logic             clk,
    input  logic             nreset,
    output logic [PSIZE-1:0] pc,
    input  logic [ISIZE-1:0] instr,
    picomips_if.master       io,
    output logic             halted
);

    localparam int OP_LSB = op_lsb(N, RA);
    localparam int RD_LSB = rd_lsb(N, RA);
    localparam int RS_LSB = rs_lsb(N);

    state_t       state;
    logic [N-1:0] regs [2**RA];
    logic [N-1:0] outport_r;
    logic         out_valid_r;

    opcode_t          op;
    logic [RA-1:0]    rd;
    logic [RA-1:0]    rs;
    logic [N-1:0]     imm;
    logic [N-1:0]     rd_val;
    logic [N-1:0]     rs_val;
    logic [N-1:0]     alu_b;
    logic [N-1:0]     alu_res;
    logic [PSIZE-1:0] pc_inc;

    assign op  = opcode_t'(instr[OP_LSB +: OP_W]);
    assign rd  = instr[RD_LSB +: RA];
    assign rs  = instr[RS_LSB +: RA];
    assign imm = instr[IMM_LSB +: N];

    // R0 reads as zero regardless of array contents.
    assign rd_val = (rd == '0) ? '0 : regs[rd];
    assign rs_val = (rs == '0) ? '0 : regs[rs];
    assign alu_b  = (op == OP_IN) ? io.in_data : rs_val;
    assign pc_inc = pc + PSIZE'(1);

    picomips_alu #(.N(N)) u_alu (
        .op     (op),
        .a      (rd_val),
        .b      (alu_b),
        .imm    (imm),
        .result (alu_res)
    );

    // An IN is pending in RUN and stays pending through WAIT_IN, where the
    // held pc keeps the same IN instruction on instr.
    assign io.in_ready  = ((state == ST_RUN) || (state == ST_WAIT_IN)) && (op == OP_IN);
    assign io.outport   = outport_r;
    assign io.out_valid = out_valid_r;

    // Main state machine. A consumed output clears out_valid first; an OUT
    // completing in the same cycle then reloads it, so back-to-back OUTs
    // keep out_valid high. A second OUT stalls only while the previous value
    // is unconsumed and out_ready is low.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pc          <= '0;
            outport_r   <= '0;
            out_valid_r <= 1'b0;
            halted      <= 1'b0;
            state       <= ST_RUN;
            for (int i = 0; i < 2**RA; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (out_valid_r && io.out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state)
                ST_RUN: begin
                    case (op)
                        OP_ADD, OP_ADDI: begin
                            if (rd != '0) regs[rd] <= alu_res;
                            pc <= pc_inc;
                        end
`ifdef PICOMIPS_MUL_EN
                        OP_MULI: begin
                            if (rd != '0) regs[rd] <= alu_res;
                            pc <= pc_inc;
                        end
`endif
                        OP_IN: begin
                            if (io.in_valid) begin
                                if (rd != '0) regs[rd] <= alu_res;
                                pc <= pc_inc;
                            end else begin
                                state <= ST_WAIT_IN;
                            end
                        end
                        OP_OUT: begin
                            if (out_valid_r && !io.out_ready) begin
                                state <= ST_WAIT_OUT;
                            end else begin
                                outport_r   <= alu_res;
                                out_valid_r <= 1'b1;
                                pc          <= pc_inc;
                            end
                        end
                        OP_BEQZ: begin
                            pc <= (rd_val == '0) ? pc + imm[PSIZE-1:0] : pc_inc;
                        end
                        OP_HALT: begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end
                        default: begin
                            pc <= pc_inc;
                        end
                    endcase
                end
                ST_WAIT_IN: begin
                    if (io.in_valid) begin
                        if (rd != '0) regs[rd] <= alu_res;
                        pc    <= pc_inc;
                        state <= ST_RUN;
                    end
                end
                ST_WAIT_OUT: begin
                    if (io.out_ready) begin
                        outport_r   <= alu_res;
                        out_valid_r <= 1'b1;
                        pc          <= pc_inc;
                        state       <= ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/picomips_core.md
PICOMIPS_CORE -- requirements
Module: picomips_core

Interface
REQ-001 SHALL have parameter N, default 8, data/register width in bits.
REQ-002 SHALL have parameter RA, default 2, register-address width; register count 2**RA.
REQ-003 SHALL have parameter PSIZE, default 5, program-counter width.
REQ-004 SHALL derive ISIZE = 3 + 2*RA + N: field order opcode[3], rd[RA], rs[RA], imm[N], MSB first.
REQ-005 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-006 SHALL have port nreset  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port pc  out  PSIZE  program address to external combinational program ROM.
REQ-008 SHALL have port instr  in  ISIZE  instruction at address pc, same cycle.
REQ-009 SHALL have port in_data  in  N  input operand (switches).
REQ-010 SHALL have ports in_valid  in  1 and in_ready  out  1  input handshake.
REQ-011 SHALL have port outport  out  N  registered output value.
REQ-012 SHALL have ports out_valid  out  1 and out_ready  in  1  output handshake.
REQ-013 SHALL have port halted  out  1  high while in HALT state.

Function
REQ-014 SHALL execute one instruction per cycle in state RUN; R0 SHALL read as 0 and ignore writes.
REQ-015 SHALL decode opcodes: 000 NOP; 001 ADD rd=rd+rs; 010 ADDI rd=rd+imm; 011 IN rd=in_data; 100 OUT outport=rs; 101 BEQZ; 110 MULI; 111 HALT.
REQ-016 SHALL perform all arithmetic modulo 2**N; no flags, no overflow trap.
REQ-017 SHALL advance pc by 1 modulo 2**PSIZE after every completed non-branching instruction; 2**PSIZE-1 wraps to 0.
REQ-018 BEQZ SHALL load pc = pc + sign-extended imm[PSIZE-1:0] (modulo 2**PSIZE) when rd == 0, else pc+1.
REQ-019 IN SHALL drive in_ready=1 combinationally; on in_valid&in_ready write rd and advance; otherwise enter WAIT_IN, hold pc, keep in_ready=1.
REQ-020 WAIT_IN SHALL return to RUN, write rd and advance pc in the cycle in_valid is high.
REQ-021 in_ready SHALL be 0 whenever the current instruction is not IN.
REQ-022 OUT SHALL load outport and set out_valid=1 next cycle; out_valid SHALL stay 1 until out_valid&out_ready, then clear.
REQ-023 OUT issued while out_valid=1 and out_ready=0 SHALL enter WAIT_OUT, hold pc, and complete on the first cycle out_ready=1 (new value loaded, out_valid stays 1).
REQ-024 HALT SHALL enter state HALT, freeze pc and registers, assert halted; exit only via reset; pending out_valid handshake SHALL still complete.
REQ-025 State machine: RUN, WAIT_IN, WAIT_OUT, HALT; no other transitions than REQ-019..024.

Reset
REQ-026 nreset low SHALL immediately set pc=0, all registers=0, outport=0, out_valid=0, halted=0, state RUN, abandoning any wait.
REQ-027 Reset release SHALL fetch address 0 on the first rising edge after nreset rises.

Configuration
REQ-028 With PICOMIPS_MUL_EN defined, MULI SHALL write rd = bits [2N-2:N-1] of signed rs*imm (Q1.(N-1) fractional product).
REQ-029 Without PICOMIPS_MUL_EN, opcode 110 SHALL behave as NOP and no multiplier SHALL be synthesised.

Structure
REQ-030 Package picomips_pkg SHALL hold the opcode enum, state enum and field-position constants.
REQ-031 Arithmetic SHALL reside in sub-module picomips_alu (ADD/ADDI/pass/MULI), combinational, parametrised by N.

Verification (N=8, RA=2, PSIZE=5)
REQ-032 ADDI R1,5; ADDI R1,-3; OUT R1 -> outport=0x02, out_valid=1 from cycle 4 until out_ready.
REQ-033 IN R2 with in_valid low 3 cycles then high with 0x7F -> in_ready high 4 cycles, pc held 3 cycles, R2=0x7F.
REQ-034 Two OUTs back-to-back with out_ready=0 -> second stalls in WAIT_OUT; out_ready=1 -> second value presented, pc advances.
REQ-035 BEQZ R0,-2 at pc=0 -> pc=30 next cycle; BEQZ R1 with R1=1 -> pc+1.
REQ-036 MUL_EN: rs=0x40 (0.5), imm=0x40 -> rd=0x20; without macro rd unchanged.
REQ-037 HALT then nreset pulse mid-WAIT_IN -> halted=0, pc=0, outport=0, out_valid=0 immediately.
